countrate_stream: RTL and testbench

COUNTRATE_STREAM -- requirements
Module: countrate_stream

---
 rtl/countrate_pkg.sv | 11 +
 rtl/countrate_snapshot_fifo.sv | 39 +++
 rtl/countrate_stream.sv | 68 ++++++
 tb/tb_countrate_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/countrate_pkg.sv
// countrate_pkg: default sizing and snapshot layout shared by the count-rate streamer
package countrate_pkg;
  localparam int NUM_OF_CHANNELS_DEF = 4;
  localparam int COUNTER_WIDTH_DEF = 32;
  localparam int WINDOW_ID_WIDTH_DEF = 16;
  typedef struct packed {
    logic [WINDOW_ID_WIDTH_DEF-1:0] window_id;
    logic [NUM_OF_CHANNELS_DEF-1:0][COUNTER_WIDTH_DEF-1:0] counts;
  } snapshot_t;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/countrate_snapshot_fifo.sv
// countrate_snapshot_fifo: synchronous snapshot FIFO whose full flag already accounts for a same-cycle pop
module countrate_snapshot_fifo
  import countrate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign do_pop = pop && !empty;
  assign full = level == (AW+1)'(DEPTH) && !do_pop;
  assign do_push = push && !full;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/countrate_stream.sv
// countrate_stream: buffers per-window channel counts and streams them as AXI-Stream beats
module countrate_stream
  import countrate_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = NUM_OF_CHANNELS_DEF,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int WINDOW_ID_WIDTH = WINDOW_ID_WIDTH_DEF,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [COUNTER_WIDTH-1:0]                             count_data [NUM_OF_CHANNELS],
  input  logic                                                 count_valid,
  output logic                                                 m_axis_tvalid,
  input  logic                                                 m_axis_tready,
  output logic                                                 m_axis_tlast,
  output logic [COUNTER_WIDTH-1:0]                             m_axis_tdata,
  output logic [WINDOW_ID_WIDTH+$clog2(NUM_OF_CHANNELS)-1:0]   m_axis_tuser,
  input  logic                                                 clear_overflow,
  output logic [15:0]                                          overflow_count
);
  localparam int IW = $clog2(NUM_OF_CHANNELS);
  localparam int SW = WINDOW_ID_WIDTH + NUM_OF_CHANNELS*COUNTER_WIDTH;
  state_t state, state_nxt;
  logic armed, full, empty, capture, drop, beat, last, pop;
  logic [$clog2(BUFFER_DEPTH):0] level;
  logic [IW-1:0] idx;
  logic [WINDOW_ID_WIDTH-1:0] window_id;
  logic [SW-1:0] din, head;
  // armed masks the strobe on the first edge after reset release
  assign capture = count_valid && armed && !full;
  assign drop = count_valid && armed && full;
  assign beat = m_axis_tvalid && m_axis_tready;
  assign last = idx == IW'(NUM_OF_CHANNELS-1);
  assign pop = beat && last;
  always_comb begin
    din = {window_id, {NUM_OF_CHANNELS*COUNTER_WIDTH{1'b0}}};
    for (int c = 0; c < NUM_OF_CHANNELS; c++) din[c*COUNTER_WIDTH +: COUNTER_WIDTH] = count_data[c];
  end
  countrate_snapshot_fifo #(.WIDTH(SW), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(capture), .pop(pop), .din(din), .dout(head),
    .full(full), .empty(empty), .level(level)
  );
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tlast = m_axis_tvalid && last;
  assign m_axis_tdata = m_axis_tvalid ? head[idx*COUNTER_WIDTH +: COUNTER_WIDTH] : '0;
  assign m_axis_tuser = m_axis_tvalid ? {head[SW-1 -: WINDOW_ID_WIDTH], idx} : '0;
  // looking at this cycle's capture lets a fresh snapshot go out one cycle after it lands
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (!empty || capture) ? SEND : IDLE;
    else if (pop) state_nxt = (level > 1 || capture) ? SEND : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      window_id <= '0;
      armed <= 1'b0;
      overflow_count <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (beat) idx <= last ? '0 : idx + IW'(1);
      if (count_valid && armed) window_id <= window_id + WINDOW_ID_WIDTH'(1);
      overflow_count <= clear_overflow ? {15'd0, drop} : overflow_count + 16'(drop && overflow_count != 16'hFFFF);
    end
endmodule

// File: tb/tb_countrate_stream.sv
// tb_countrate_stream: randomized scoreboard bench for countrate_stream
module tb_countrate_stream;
  localparam int N = 4;
  localparam int D = 2;
  typedef struct {
    logic [31:0] data;
    logic [17:0] user;
    logic        last;
  } beat_t;
  logic clk = 0, rst = 0, count_valid = 0, tready = 0, clear = 0;
  logic [31:0] count_data [N];
  logic tvalid, tlast;
  logic [31:0] tdata;
  logic [17:0] tuser;
  logic [15:0] overflow_count;
  int checks = 0, errors = 0;
  beat_t sb[$];
  int occ = 0;
  logic [15:0] m_wid = 0, m_ovf = 0;
  bit m_armed = 0;
  logic stall = 0;
  logic [31:0] pd;
  logic [17:0] pu;
  logic pl;
  beat_t e;

  countrate_stream dut (
    .clk(clk), .rst(rst), .count_data(count_data), .count_valid(count_valid),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .clear_overflow(clear), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a snapshot is kept if fewer than D are still unfinished once this cycle's last beat leaves
  always @(negedge clk) begin
    bit drop;
    drop = 0;
    if (!rst) begin
      sb.delete();
      occ = 0;
      m_wid = 0;
      m_ovf = 0;
      m_armed = 0;
    end else begin
      chk("overflow_count", overflow_count, m_ovf);
      if (tvalid && tready && tlast) occ--;
      if (!m_armed) m_armed = 1;
      else if (count_valid) begin
        if (occ < D) begin
          occ++;
          for (int c = 0; c < N; c++) sb.push_back('{count_data[c], {m_wid, 2'(c)}, c == N-1});
        end else drop = 1;
        m_wid++;
      end
      if (clear) m_ovf = drop ? 16'd1 : 16'd0;
      else if (drop && m_ovf != 16'hFFFF) m_ovf++;
    end
  end

  always @(negedge clk) begin
    if (!rst) stall = 0;
    else begin
      if (stall) chk("stable", {tvalid, tlast, tuser, tdata}, {1'b1, pl, pu, pd});
      if (tvalid && tready) begin
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat", {tlast, tuser, tdata}, {e.last, e.user, e.data});
        end
      end
      stall = tvalid && !tready;
      pd = tdata;
      pu = tuser;
      pl = tlast;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    count_data[0] = a;
    count_data[1] = b;
    count_data[2] = c;
    count_data[3] = d;
    count_valid = 1;
    step;
    count_valid = 0;
  endtask

  task automatic do_reset;
    rst = 0;
    count_valid = 0;
    clear = 0;
    repeat (2) step;
    rst = 1;
    step;
  endtask

  task automatic drain;
    tready = 1;
    repeat (20) step;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    for (int c = 0; c < N; c++) count_data[c] = 0;
    repeat (2) step;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_ovf", overflow_count, 0);
    rst = 1;
    step;
    // single window, first beat one cycle after capture
    tready = 1;
    pulse(10, 20, 30, 40);
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", tvalid, 1);
      chk("t1_data", tdata, 10 * (k + 1));
      chk("t1_user", tuser, k);
      chk("t1_last", tlast, k == 3);
      step;
    end
    chk("t1_idle", tvalid, 0);
    // overflow with a stalled sink, then back-to-back drain
    do_reset;
    tready = 0;
    for (int k = 0; k < 3; k++) begin
      pulse(100 + k, 200 + k, 300 + k, 400 + k);
      step;
    end
    chk("t2_ovf", overflow_count, 1);
    tready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_valid", tvalid, 1);
      chk("t2_id", tuser[17:2], k / 4);
      step;
    end
    chk("t2_idle", tvalid, 0);
    pulse(7, 8, 9, 10);
    chk("t2_next_id", tuser[17:2], 3);
    drain;
    // capture into a full buffer while its head's last beat leaves
    tready = 0;
    pulse(11, 12, 13, 14);
    step;
    pulse(15, 16, 17, 18);
    step;
    tready = 1;
    for (int i = 0; i < 20 && !(tvalid && tlast); i++) step;
    chk("t3_last_seen", tvalid && tlast, 1);
    pulse(19, 20, 21, 22);
    chk("t3_ovf", overflow_count, 1);
    drain;
    // random sink backpressure over 1000 windows
    do_reset;
    n = 0;
    while (n < 1000) begin
      tready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 63) == 0;
      count_valid = $urandom_range(0, 3) == 0;
      if (count_valid) begin
        n++;
        for (int c = 0; c < N; c++) count_data[c] = $urandom;
      end
      step;
    end
    count_valid = 0;
    clear = 0;
    drain;
    // reset on the second beat of a packet
    do_reset;
    tready = 1;
    pulse(1, 2, 3, 4);
    step;
    chk("t5_beat2", tuser, 1);
    rst = 0;
    #1;
    chk("t5_tvalid", tvalid, 0);
    chk("t5_tdata", tdata, 0);
    chk("t5_tuser", tuser, 0);
    chk("t5_tlast", tlast, 0);
    step;
    rst = 1;
    step;
    pulse(5, 6, 7, 8);
    chk("t5_new_valid", tvalid, 1);
    chk("t5_new_user", tuser, 0);
    chk("t5_new_data", tdata, 5);
    drain;
    // saturation, then drop together with clear
    do_reset;
    tready = 0;
    count_valid = 1;
    repeat (65542) step;
    count_valid = 0;
    step;
    chk("t6_sat", overflow_count, 16'hFFFF);
    count_valid = 1;
    clear = 1;
    step;
    count_valid = 0;
    clear = 0;
    chk("t6_clear_drop", overflow_count, 1);
    drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
